im_boot_loader: RTL and testbench
=================================

# im_boot_loader

Boot-time instruction loader in front of the pipelined CPU's instruction memory. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive IM word addresses. It zero-fills the unused tail so stale words decode as NOPs, and holds the CPU in reset until the image is complete. It then releases the CPU and pulses `dump_o` after a programmed number of run cycles, marking the point where register and data-memory state is sampled.

## Interface
- `DEPTH`, 32: IM depth in words; must be a power of two, 2..1024.
- `RUN_CYCLES`, 30: CPU clock cycles after release before `dump_o` pulses; must be 1..65535.
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `load_start_i`  in  1  starts a new load; honoured in IDLE, RUN, DONE and ERR; ignored in LOAD, FILL and HOLD.
- `in_valid_i`  in  1  `in_data_i` and `in_last_i` are valid.
- `in_data_i`  in  32  instruction word.
- `in_last_i`  in  1  marks the final word of the image.
- `in_ready_o`  out  1  loader accepts a word this cycle.
- `im_we_o`  out  1  IM write strobe.
- `im_addr_o`  out  32  IM byte address, always a multiple of 4.
- `im_wdata_o`  out  32  IM write data.
- `cpu_rst_n_o`  out  1  drives the CPU `rst_n`; 0 holds the CPU in reset.
- `dump_o`  out  1  one-cycle pulse when the run window expires.
- `done_o`  out  1  high in DONE.
- `err_o`  out  1  high in ERR (overflow).
- `word_count_o`  out  $clog2(DEPTH)+1  number of words accepted in the current load.

## Operation
- States: IDLE, LOAD, FILL, HOLD, RUN, DONE, ERR.
- IDLE: `load_start_i` → LOAD; `word_count_o` ← 0; write pointer ← 0.
- LOAD: `in_ready_o` = 1.
  - On each accept (`in_valid_i` and `in_ready_o`): write `in_data_i` at the pointer, then increment the pointer and the count.
  - Accept with `in_last_i`, pointer < DEPTH-1 → FILL.
  - Accept with `in_last_i`, pointer = DEPTH-1 → HOLD.
  - Accept without `in_last_i`, pointer = DEPTH-1 → the word is written, then ERR (overflow: no `in_last_i` within DEPTH words).
- FILL: `in_ready_o` = 0. Write 0 to each remaining address, one per cycle. After writing address DEPTH-1 → HOLD.
- HOLD: one cycle, no writes; lets the final IM write settle → RUN.
- RUN:
  - `cpu_rst_n_o` = 1. Run counter starts at 0 on entry and increments every cycle.
  - When counter = RUN_CYCLES-1, `dump_o` = 1 for that cycle → DONE.
  - `load_start_i` → LOAD (CPU re-held in reset, counts cleared).
- DONE: `cpu_rst_n_o` stays 1; `done_o` = 1; `load_start_i` → LOAD.
- ERR: `cpu_rst_n_o` = 0; `err_o` = 1; `load_start_i` → LOAD.
- `cpu_rst_n_o` = 0 in every state except RUN and DONE.
- Address arithmetic: `im_addr_o` = {pointer, 2'b00}, zero-extended to 32 bits. The pointer never wraps; overflow goes to ERR instead.
- `load_start_i` with `in_valid_i` in the same IDLE cycle: the start is taken; the word is not accepted until the next cycle.

## Timing
- All outputs are registered.
- Reset values: `cpu_rst_n_o`=0, `in_ready_o`=0, `im_we_o`=0, `im_addr_o`=0, `im_wdata_o`=0, `dump_o`=0, `done_o`=0, `err_o`=0, `word_count_o`=0. State = IDLE.
- Write latency: a word accepted at edge N appears on `im_we_o`/`im_addr_o`/`im_wdata_o` during cycle N+1. IM commits it at edge N+2.
- `in_ready_o` rises the cycle after LOAD is entered and falls the cycle after the last-word or overflow accept.
- With back-to-back valid words, throughput is one word per cycle.
- `cpu_rst_n_o` rises one cycle after the last IM write strobe (the HOLD cycle).
- `dump_o` rises exactly RUN_CYCLES cycles after the `cpu_rst_n_o` rising edge.
- `rst_i` asserted in any state, including mid-LOAD or mid-FILL:
  - next cycle is IDLE with reset values;
  - a write strobe already registered is dropped;
  - the IM contents are left partial.

## Structure
- Shared package `im_boot_pkg`:
  - state enum `boot_state_t`;
  - `WORD_W`=32;
  - `NOP_WORD`=32'h0.
- One natural sub-module, `im_boot_run_timer`: the RUN_CYCLES down-counter with `start_i`, `clear_i` and an `expire_o` pulse. Everything else stays in the top FSM.

## Test plan
- Load 5 words (A..E) with `in_last_i` on E, DEPTH=32 → addresses 0,4,...,16 hold A..E; addresses 20..124 are written 0; `word_count_o`=5; `cpu_rst_n_o` rises 1 cycle after the write to address 124.
- `in_valid_i` toggling 1,0,1,0 during LOAD → only the valid cycles are written; the addresses stay contiguous.
- Send 32 words with no `in_last_i` → 32 writes, `err_o`=1, `cpu_rst_n_o` stays 0; then `load_start_i` → LOAD with `err_o`=0 and count 0.
- Send exactly 32 words with `in_last_i` on the 32nd → no FILL writes; HOLD then RUN; `err_o`=0.
- RUN_CYCLES=30 → `dump_o` high for exactly 1 cycle, 30 cycles after `cpu_rst_n_o` rises; `done_o`=1 afterwards.
- `rst_i` pulsed mid-FILL → next cycle all outputs at reset values, `im_we_o`=0, state IDLE; a subsequent full load completes normally.

Source files
------------

// File: rtl/im_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   boot_state_t : loader FSM states
//   WORD_W       : instruction / IM data width
//   NOP_WORD     : value written to unused IM tail words
package im_boot_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFill,
    StHold,
    StRun,
    StDone,
    StErr
  } boot_state_t;

endpackage

// File: rtl/im_boot_loader_if.sv
// Instruction-word stream into the boot loader (valid/ready handshake).
//   in_valid : in_data / in_last are valid
//   in_data  : instruction word
//   in_last  : final word of the image
//   in_ready : loader accepts a word this cycle
// master = word source, slave = loader.
interface im_boot_loader_if;
  import im_boot_pkg::*;

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/im_boot_run_timer.sv
// Run-window timer: loaded with RUN_CYCLES-1 on start_i, counts down once per cycle and
// raises expire_o (combinational) in the cycle the count reaches zero.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : arm the timer (first cycle of the run window follows)
//   clear_i      : abandon the current window
//   expire_o     : high in the last cycle of the window
module im_boot_run_timer #(
  parameter int unsigned RUN_CYCLES = 30
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic clear_i,
  output logic expire_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        run_q, run_d;

  assign expire_o = run_q && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start_i) begin
      run_d = 1'b1;
      cnt_d = 16'(RUN_CYCLES - 1);
    end else if (expire_o) begin
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/im_boot_loader.sv
// Boot-time instruction loader: streams words into consecutive IM addresses, zero-fills
// the unused tail, holds the CPU in reset until the image is complete, then releases it
// and pulses dump_o after RUN_CYCLES cycles.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_start_i  : start a new load (honoured in IDLE, RUN, DONE, ERR)
//   in_if         : instruction-word stream (slave side)
//   im_we_o, im_addr_o, im_wdata_o : IM write port (byte address, word aligned)
//   cpu_rst_n_o   : CPU reset, low holds the CPU
//   dump_o        : one-cycle pulse at end of the run window
//   done_o, err_o : run complete / overflow (no last word within DEPTH words)
//   word_count_o  : words accepted in the current load
// All outputs are registered.
module im_boot_loader
  import im_boot_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned RUN_CYCLES = 30
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_start_i,
  im_boot_loader_if.slave        in_if,
  output logic                   im_we_o,
  output logic [31:0]            im_addr_o,
  output logic [WORD_W-1:0]      im_wdata_o,
  output logic                   cpu_rst_n_o,
  output logic                   dump_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [$clog2(DEPTH):0] word_count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  boot_state_t       state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [PtrW-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic              rst_n_q, rst_n_d;
  logic              dump_q, dump_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic              timer_start, timer_clear, timer_expire;

  // ready_q mirrors "in LOAD", so it doubles as the handshake qualifier.
  assign accept = in_if.in_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    timer_clear = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (load_start_i) begin
          state_d = StLoad;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = in_if.in_data;
          count_d = count_q + 1'b1;
          // Pointer stops at the last word; running past it is an overflow, not a wrap.
          if (ptr_q == LastPtr) begin
            state_d = in_if.in_last ? StHold : StErr;
          end else begin
            ptr_d = ptr_q + 1'b1;
            if (in_if.in_last) state_d = StFill;
          end
        end
      end
      StFill: begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = NOP_WORD;
        if (ptr_q == LastPtr) state_d = StHold;
        else                  ptr_d   = ptr_q + 1'b1;
      end
      StHold: state_d = StRun;
      StRun: begin
        if (load_start_i) begin
          state_d     = StLoad;
          ptr_d       = '0;
          count_d     = '0;
          timer_clear = 1'b1;
        end else if (timer_expire) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    timer_start = (state_d == StRun) && (state_q != StRun);
    ready_d     = (state_d == StLoad);
    rst_n_d     = (state_d == StRun) || (state_d == StDone);
    dump_d      = (state_q == StRun) && (state_d == StDone);
    done_d      = (state_d == StDone);
    err_d       = (state_d == StErr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      rst_n_q <= 1'b0;
      dump_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      rst_n_q <= rst_n_d;
      dump_q  <= dump_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  im_boot_run_timer #(
    .RUN_CYCLES(RUN_CYCLES)
  ) u_run_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (timer_start),
    .clear_i (timer_clear),
    .expire_o(timer_expire)
  );

  assign in_if.in_ready = ready_q;
  assign im_we_o        = we_q;
  assign im_addr_o      = {{(30 - PtrW){1'b0}}, addr_q, 2'b00};
  assign im_wdata_o     = wdata_q;
  assign cpu_rst_n_o    = rst_n_q;
  assign dump_o         = dump_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign word_count_o   = count_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed bench for im_boot_loader with an IM-write scoreboard.
module tb_im_boot_loader;
  import im_boot_pkg::*;

  localparam int unsigned DEPTH      = 32;
  localparam int unsigned RUN_CYCLES = 30;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   load_start;
  logic                   im_we;
  logic [31:0]            im_addr;
  logic [WORD_W-1:0]      im_wdata;
  logic                   cpu_rst_n;
  logic                   dump;
  logic                   done;
  logic                   err;
  logic [$clog2(DEPTH):0] word_count;

  im_boot_loader_if bus ();

  im_boot_loader #(
    .DEPTH     (DEPTH),
    .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_start_i(load_start),
    .in_if       (bus),
    .im_we_o     (im_we),
    .im_addr_o   (im_addr),
    .im_wdata_o  (im_wdata),
    .cpu_rst_n_o (cpu_rst_n),
    .dump_o      (dump),
    .done_o      (done),
    .err_o       (err),
    .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int wr_cnt     = 0;
  int last_we_cyc = -1;
  int exp_ptr    = 0;
  int last_acc   = 0;
  logic [63:0] last_wr = '0;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every IM strobe must match the head of the scoreboard.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (im_we === 1'b1) begin
        wr_cnt++;
        last_we_cyc = cyc;
        last_wr     = {im_addr, im_wdata};
        chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("write_addr_data", {im_addr, im_wdata}, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    exp_ptr    = 0;
  endtask

  task automatic send(input logic [31:0] d, input bit l);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok       = 1'b1;
        last_acc = cyc;
        exp_q.push_back({32'(exp_ptr * 4), d});
        exp_ptr++;
      end
      tick(1);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("word_accepted", 64'(ok), 64'd1);
  endtask

  task automatic push_fill();
    for (int a = exp_ptr; a < int'(DEPTH); a++) exp_q.push_back({32'(a * 4), NOP_WORD});
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    tick(n);
  endtask

  task automatic wait_cpu(output int c);
    c = -1;
    for (int i = 0; i < 200 && c < 0; i++) begin
      @(negedge clk);
      if (cpu_rst_n === 1'b1) c = cyc;
    end
    chk("cpu_release_seen", 64'(c >= 0), 64'd1);
  endtask

  task automatic wait_dump(output int c);
    c = -1;
    for (int i = 0; i < 200 && c < 0; i++) begin
      @(negedge clk);
      if (dump === 1'b1) c = cyc;
    end
    chk("dump_seen", 64'(c >= 0), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({cpu_rst_n, bus.in_ready, im_we, dump, done, err}), 64'd0);
    chk({tag, "_addr"}, 64'(im_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(im_wdata), 64'd0);
    chk({tag, "_count"}, 64'(word_count), 64'd0);
  endtask

  task automatic run_window(input string tag, input int c_rise);
    int c_dump;
    wait_dump(c_dump);
    chk({tag, "_dump_delay"}, 64'(c_dump - c_rise), 64'(RUN_CYCLES));
    @(negedge clk);
    chk({tag, "_after_dump"}, 64'({dump, done, cpu_rst_n}), 64'b011);
  endtask

  initial begin
    int c_rise;
    int first_acc;
    rst          = 1'b1;
    load_start   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    tick(3);
    @(negedge clk);
    check_reset("reset");
    tick(1);
    rst = 1'b0;
    // Valid word without a start must not be taken in IDLE.
    bus.in_valid = 1'b1;
    tick(2);
    bus.in_valid = 1'b0;
    chk("idle_no_ready", 64'(bus.in_ready), 64'd0);

    // 5-word image with valid toggling, tail zero-filled.
    wr_cnt = 0;
    start_load();
    @(negedge clk);
    chk("t1_ready", 64'(bus.in_ready), 64'd1);
    tick(1);
    send(32'hA0A0_0001, 1'b0); idle(1);
    send(32'hB0B0_0002, 1'b0); idle(1);
    send(32'hC0C0_0003, 1'b0);
    send(32'hD0D0_0004, 1'b0);
    send(32'hE0E0_0005, 1'b1);
    push_fill();
    wait_cpu(c_rise);
    chk("t1_release_timing", 64'(c_rise), 64'(last_we_cyc + 1));
    chk("t1_last_write", last_wr, {32'd124, NOP_WORD});
    chk("t1_count", 64'(word_count), 64'd5);
    chk("t1_writes", 64'(wr_cnt), 64'd32);
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    run_window("t1", c_rise);

    // Overflow: 32 words with no last marker.
    tick(1);
    start_load();
    @(negedge clk);
    chk("t2_start", 64'({err, bus.in_ready, word_count}), {58'd0, 1'b0, 1'b1, 6'd0});
    tick(1);
    wr_cnt = 0;
    send(32'hC000_0000, 1'b0);
    first_acc = last_acc;
    for (int i = 1; i < 32; i++) send(32'hC000_0000 + 32'(i), 1'b0);
    chk("t2_throughput", 64'(last_acc - first_acc), 64'd31);
    @(negedge clk);
    chk("t2_err_state", 64'({err, bus.in_ready, cpu_rst_n}), 64'b100);
    chk("t2_count", 64'(word_count), 64'd32);
    repeat (3) @(negedge clk);
    chk("t2_writes", 64'(wr_cnt), 64'd32);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t2_err_hold", 64'({err, cpu_rst_n}), 64'b10);
    tick(1);
    start_load();
    @(negedge clk);
    chk("t2_restart", 64'({err, bus.in_ready, word_count}), {58'd0, 1'b0, 1'b1, 6'd0});
    tick(1);

    // Exactly DEPTH words: no fill, HOLD then RUN.
    wr_cnt = 0;
    for (int i = 0; i < 32; i++) send(32'h5A00_0000 + 32'(i), (i == 31));
    push_fill();
    wait_cpu(c_rise);
    chk("t3_release_timing", 64'(c_rise), 64'(last_we_cyc + 1));
    chk("t3_release_vs_accept", 64'(c_rise - last_acc), 64'd2);
    chk("t3_writes", 64'(wr_cnt), 64'd32);
    chk("t3_err_count", 64'({err, word_count}), 64'd32);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    run_window("t3", c_rise);

    // Reset in the middle of FILL, then a clean reload.
    tick(1);
    start_load();
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    send(32'h3333_3333, 1'b1);
    push_fill();
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset("t4_after_rst");
    tick(1);
    wr_cnt = 0;
    start_load();
    send(32'h4444_0000, 1'b0);
    send(32'h4444_0001, 1'b0);
    send(32'h4444_0002, 1'b0);
    send(32'h4444_0003, 1'b1);
    push_fill();
    wait_cpu(c_rise);
    chk("t4_release_timing", 64'(c_rise), 64'(last_we_cyc + 1));
    chk("t4_count", 64'(word_count), 64'd4);
    chk("t4_writes", 64'(wr_cnt), 64'd32);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    run_window("t4", c_rise);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
